// File: rtl/fir_output_capture.sv
// -----------------------------------------------------------------------------
// fir_output_capture
//   Captures filtered samples from FIR_Filter data_out into an on-chip buffer.
//   After an arm pulse, the block drops SKIP valid samples (the filter fill
//   latency), then records DEPTH consecutive valid samples and tracks the
//   largest magnitude seen during the run. A registered read port serves a
//   host or bench checker in any state.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       arm pulse, honoured only in IDLE and DONE
//   data_in     filtered sample (N-bit two's complement)
//   data_valid  data_in qualifier; low stalls counting and capture
//   rd_en       read request
//   rd_addr     read address
//   rd_data     registered buffer word, holds while rd_en is low
//   rd_valid    one-cycle pulse in the cycle after rd_en
//   busy        high while skipping or capturing
//   done        high once the buffer is full, until re-armed or reset
//   wr_addr     next write slot, i.e. samples captured so far
//   peak        largest |sample| captured this run (unsigned)
// -----------------------------------------------------------------------------
module fir_output_capture #(
    parameter int N     = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int SKIP  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  data_in,
    input  logic          data_valid,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  peak
);

    // Skip counter only needs to reach SKIP-1; the SKIP-th sample exits.
    localparam int unsigned SW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [N-1:0]  MOST_NEG  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  MOST_POS  = {1'b0, {(N-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [SW-1:0]  skip_cnt;
    logic [N-1:0]   mem [DEPTH];
    logic [N-1:0]   mag;
    logic           arm;
    logic           skip_hit;
    logic           cap_wr;
    logic           last_wr;

    // A sample arriving on the arming edge is seen while still in IDLE/DONE,
    // so it is neither counted nor stored.
    assign arm      = start && ((state == S_IDLE) || (state == S_DONE));
    assign skip_hit = (state == S_SKIP) && data_valid && (skip_cnt == SKIP_LAST);
    assign cap_wr   = (state == S_CAPTURE) && data_valid;
    assign last_wr  = cap_wr && (wr_addr == ADDR_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (SKIP == 0) ? S_CAPTURE : S_SKIP;
                end
            end
            S_SKIP: begin
                if (skip_hit) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (last_wr) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == S_SKIP) || (state == S_CAPTURE);
        done = (state == S_DONE);
    end

    // |x| in N bits; the most negative value has no positive twin and saturates.
    always_comb begin
        mag = data_in;
        if (data_in[N-1]) begin
            mag = (data_in == MOST_NEG) ? MOST_POS : -data_in;
        end
    end

    // Counters, peak tracker and registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr  <= '0;
            peak     <= '0;
            skip_cnt <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end

            if (arm) begin
                wr_addr  <= '0;
                peak     <= '0;
                skip_cnt <= '0;
            end else if ((state == S_SKIP) && data_valid) begin
                skip_cnt <= skip_cnt + SW'(1);
            end else if (cap_wr) begin
                // DEPTH is a power of two, so the last write wraps to 0.
                wr_addr <= wr_addr + AW'(1);
                if (mag > peak) begin
                    peak <= mag;
                end
            end
        end
    end

    // Buffer storage; never reset. A same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (cap_wr) begin
            mem[wr_addr] <= data_in;
        end
    end

endmodule
